// File: rtl/led_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_driver
//  Description : Turns a 24-bit GRB colour word into three glitch-free PWM
//                outputs for a discrete RGB LED. A new word is held in a
//                pending buffer and applied only at a PWM period boundary,
//                so no runt period is ever produced.
//
//                A prescaler divides i_clk by PRESCALE to make PWM ticks.
//                An 8-bit period counter runs 0..254 on ticks, so one
//                period is 255 ticks. Channel lit = (counter < duty).
//
//                Optional build macro LED_PWM_FADE_EN:
//                  defined   - at each boundary every duty steps by one
//                              toward the last latched word, and the ack
//                              fires when all three channels arrive.
//                  undefined - duties jump to the new word at one boundary.
//
//  Ports       : i_clk         system clock
//                i_reset_n     synchronous active-low reset
//                i_led_data    colour word [23:16]=G [15:8]=R [7:0]=B
//                i_latch       one-cycle strobe, i_led_data valid
//                o_pwm_g/r/b   registered PWM pins (polarity ACTIVE_HIGH)
//                o_pending     a word is waiting for a period boundary
//                o_update_ack  one-cycle pulse after the duties reach the word
//
//  Revision    : 1.0  initial release
// ============================================================================
module led_pwm_driver #(
    parameter int PRESCALE    = 4,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [23:0] i_led_data,
    input  logic        i_latch,
    output logic        o_pwm_g,
    output logic        o_pwm_r,
    output logic        o_pwm_b,
    output logic        o_pending,
    output logic        o_update_ack
);

    // A one-bit prescaler is kept even for PRESCALE = 1; it simply stays 0.
    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [7:0]      CNT_LAST = 8'd254;
    localparam logic            UNLIT    = ~ACTIVE_HIGH;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [23:0]     duty_q, duty_d;
    logic [23:0]     pend_q, pend_d;
    logic            ack_q, ack_d;
    logic [2:0]      pwm_q, pwm_d;

    logic            w_tick;
    logic            w_boundary;

    // ------------------------------------------------------------------
    // Timebase: prescaler and period counter
    // ------------------------------------------------------------------
    assign w_tick     = (presc_q == PS_LAST);
    assign w_boundary = w_tick && (cnt_q == CNT_LAST);

    always_comb begin
        presc_d = w_tick ? '0 : presc_q + 1'b1;
        cnt_d   = cnt_q;
        if (w_tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Compare stage, registered so the pins never glitch
    // ------------------------------------------------------------------
    always_comb begin
        pwm_d[2] = (cnt_q < duty_q[23:16]) ^ UNLIT;
        pwm_d[1] = (cnt_q < duty_q[15:8])  ^ UNLIT;
        pwm_d[0] = (cnt_q < duty_q[7:0])   ^ UNLIT;
    end

`ifdef LED_PWM_FADE_EN
    // ------------------------------------------------------------------
    // Fade: the pending register holds the target; duties creep toward it
    // one step per boundary. A latch on the boundary itself retargets and
    // takes the first step in the same cycle.
    // ------------------------------------------------------------------
    logic [23:0] w_tgt;
    logic [23:0] w_step;

    function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt);
        logic [7:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + 8'd1;
        end else if (cur > tgt) begin
            nxt = cur - 8'd1;
        end
        return nxt;
    endfunction

    always_comb begin
        w_tgt  = i_latch ? i_led_data : pend_q;
        w_step = {step_toward(duty_q[23:16], w_tgt[23:16]),
                  step_toward(duty_q[15:8],  w_tgt[15:8]),
                  step_toward(duty_q[7:0],   w_tgt[7:0])};
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        duty_d  = duty_q;
        ack_d   = 1'b0;
        if (i_latch) begin
            pend_d  = i_led_data;
            state_d = ST_PENDING;
        end
        if (w_boundary && (i_latch || (state_q == ST_PENDING))) begin
            duty_d = w_step;
            if (w_step == w_tgt) begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
            end else begin
                state_d = ST_PENDING;
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Double buffer: a latch on the boundary bypasses the pending register
    // and goes straight to the active duties.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        duty_d  = duty_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_latch) begin
                    if (w_boundary) begin
                        duty_d = i_led_data;
                        ack_d  = 1'b1;
                    end else begin
                        pend_d  = i_led_data;
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (w_boundary) begin
                    duty_d  = i_latch ? i_led_data : pend_q;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_latch) begin
                    pend_d = i_led_data;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            cnt_q   <= 8'd0;
            duty_q  <= 24'd0;
            pend_q  <= 24'd0;
            ack_q   <= 1'b0;
            pwm_q   <= {3{UNLIT}};
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            pwm_q   <= pwm_d;
        end
    end

    assign o_pwm_g      = pwm_q[2];
    assign o_pwm_r      = pwm_q[1];
    assign o_pwm_b      = pwm_q[0];
    assign o_pending    = (state_q == ST_PENDING);
    assign o_update_ack = ack_q;

endmodule
`default_nettype wire
